conv_pu_mac: RTL and testbench

Convolution processing unit: the responder side of the convolution control FSM's PU handshake. It consumes the per-tap `start_pu` strobes and the `latch_result` strobe, multiply-accumulates the pixel/weight words returned by the synchronous image and kernel memories, and emits one quantized result per output pixel. Results carry a feature-map write address into the 26x26 output buffer. `done_pu` returns to the FSM as a per-result completion pulse.

---
 rtl/conv_pu_mac.sv | 122 ++++++++++++
 tb/tb_conv_pu_mac.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pu_mac.sv
// conv_pu_mac: PU responder that multiply-accumulates taps and emits quantized results.
// Optional feature macro CONV_PU_RELU_EN selects unsigned ReLU clamp instead of signed saturation.
module conv_pu_mac #(
  parameter int PIX_W        = 8,
  parameter int WGT_W        = 8,
  parameter int ACC_W        = 21,
  parameter int OUT_W        = 8,
  parameter int SHIFT        = 0,
  parameter int KERNEL_SIZE  = 9,
  parameter int OUT_MAP_SIZE = 676
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_pu,
  input  logic                    latch_result,
  input  logic [PIX_W-1:0]        pixel_in,
  input  logic signed [WGT_W-1:0] weight_in,
  output logic [OUT_W-1:0]        res_data,
  output logic [9:0]              res_addr,
  output logic                    res_valid,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    done_pu,
  output logic                    frame_done,
  output logic                    err_count
);

  localparam int PROD_W = PIX_W + WGT_W + 1;

  localparam logic [3:0] L_KS   = 4'(KERNEL_SIZE);
  localparam logic [9:0] L_LAST = 10'(OUT_MAP_SIZE - 1);

  localparam logic signed [ACC_W-1:0] L_SMAX =
    ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] L_SMIN =
    ACC_W'(-(2 ** (OUT_W - 1)));
  localparam logic signed [ACC_W-1:0] L_UMAX =
    ACC_W'((2 ** OUT_W) - 1);

  logic                    r_mac_en_d1;
  logic                    r_latch_d1;
  logic signed [ACC_W-1:0] r_acc;
  logic [3:0]              r_tap_cnt;
  logic [9:0]              r_out_cnt;
  logic [OUT_W-1:0]        r_res_data;
  logic [9:0]              r_res_addr;
  logic                    r_res_valid;
  logic signed [ACC_W-1:0] r_acc_out;
  logic                    r_frame_done;
  logic                    r_err;

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_q;
  logic [OUT_W-1:0]         w_sat;

  // pixel is unsigned: prepend a zero so the signed multiply treats it as positive
  assign w_prod     = $signed({1'b0, pixel_in}) * $signed(weight_in);
  assign w_prod_ext = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_q        = r_acc >>> SHIFT;

  always_comb begin
    w_sat = w_q[OUT_W-1:0];
`ifdef CONV_PU_RELU_EN
    if (w_q[ACC_W-1])
      w_sat = '0;
    else if (w_q > L_UMAX)
      w_sat = '1;
`else
    if (w_q > L_SMAX)
      w_sat = {1'b0, {(OUT_W-1){1'b1}}};
    else if (w_q < L_SMIN)
      w_sat = {1'b1, {(OUT_W-1){1'b0}}};
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mac_en_d1  <= 1'b0;
      r_latch_d1   <= 1'b0;
      r_acc        <= '0;
      r_tap_cnt    <= '0;
      r_out_cnt    <= '0;
      r_res_data   <= '0;
      r_res_addr   <= '0;
      r_res_valid  <= 1'b0;
      r_acc_out    <= '0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_mac_en_d1  <= start_pu;
      r_latch_d1   <= latch_result;
      r_res_valid  <= r_latch_d1;
      r_frame_done <= r_latch_d1 && (r_out_cnt == L_LAST);
      if (r_latch_d1) begin
        r_acc_out  <= r_acc;
        r_res_data <= w_sat;
        r_res_addr <= r_out_cnt;
        r_out_cnt  <= (r_out_cnt == L_LAST) ? '0 : r_out_cnt + 10'd1;
        if (r_tap_cnt != L_KS)
          r_err <= 1'b1;
      end
      // a tap landing on the latch cycle starts the next pixel
      if (r_latch_d1) begin
        r_acc     <= r_mac_en_d1 ? w_prod_ext : '0;
        r_tap_cnt <= r_mac_en_d1 ? 4'd1 : 4'd0;
      end else if (r_mac_en_d1) begin
        r_acc <= r_acc + w_prod_ext;
        if (r_tap_cnt != 4'd15)
          r_tap_cnt <= r_tap_cnt + 4'd1;
      end
    end
  end

  assign res_data   = r_res_data;
  assign res_addr   = r_res_addr;
  assign res_valid  = r_res_valid;
  assign acc_out    = r_acc_out;
  assign done_pu    = r_res_valid;
  assign frame_done = r_frame_done;
  assign err_count  = r_err;

endmodule

// File: tb/tb_conv_pu_mac.sv
// tb_conv_pu_mac: directed bench with a queue-based result model for conv_pu_mac.
// Two instances run side by side: SHIFT=0 and SHIFT=12.
module tb_conv_pu_mac;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start_pu = 1'b0;
  logic              latch_result = 1'b0;
  logic [7:0]        pixel_in = '0;
  logic signed [7:0] weight_in = '0;

  logic [7:0]         d0_data, d1_data;
  logic [9:0]         d0_addr, d1_addr;
  logic               d0_valid, d1_valid;
  logic signed [20:0] d0_acc, d1_acc;
  logic               d0_done, d1_done;
  logic               d0_fd, d1_fd;
  logic               d0_err, d1_err;

  conv_pu_mac u_dut0 (
    .clk(clk), .reset(reset),
    .start_pu(start_pu), .latch_result(latch_result),
    .pixel_in(pixel_in), .weight_in(weight_in),
    .res_data(d0_data), .res_addr(d0_addr),
    .res_valid(d0_valid), .acc_out(d0_acc),
    .done_pu(d0_done), .frame_done(d0_fd),
    .err_count(d0_err)
  );

  conv_pu_mac #(.SHIFT(12)) u_dut12 (
    .clk(clk), .reset(reset),
    .start_pu(start_pu), .latch_result(latch_result),
    .pixel_in(pixel_in), .weight_in(weight_in),
    .res_data(d1_data), .res_addr(d1_addr),
    .res_valid(d1_valid), .acc_out(d1_acc),
    .done_pu(d1_done), .frame_done(d1_fd),
    .err_count(d1_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d0;
    int d12;
    int acc;
    int addr;
    bit err;
  } exp_t;

  exp_t m_q[$];
  int   m_addr = 0;
  bit   m_err_sticky = 0;
  bit   m_err_cur = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_fd = 0;
  int   g_pix[16];
  int   g_wgt[16];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int quant(input int acc, input int sh);
    int v;
    v = acc >>> sh;
`ifdef CONV_PU_RELU_EN
    if (v < 0) v = 0;
    if (v > 255) v = 255;
`else
    if (v < -128) v = -128;
    if (v > 127) v = 127;
`endif
    return v & 255;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_addr = 0;
    m_err_sticky = 0;
    m_err_cur = 0;
  endtask

  task automatic drive(input bit s, input bit l, input int p, input int w);
    @(negedge clk);
    start_pu     = s;
    latch_result = l;
    pixel_in     = p[7:0];
    weight_in    = w[7:0];
  endtask

  task automatic seq(input int n);
    exp_t e;
    int sum;
    sum = 0;
    for (int k = 0; k < n; k++) sum += g_pix[k] * g_wgt[k];
    if (n != 9) m_err_sticky = 1;
    e.d0   = quant(sum, 0);
    e.d12  = quant(sum, 12);
    e.acc  = sum;
    e.addr = m_addr;
    e.err  = m_err_sticky;
    m_q.push_back(e);
    m_addr = (m_addr == 675) ? 0 : m_addr + 1;
    for (int t = 0; t <= n; t++)
      drive(t < n, t == n,
            (t >= 1) ? g_pix[t-1] : 0,
            (t >= 1) ? g_wgt[t-1] : 0);
  endtask

  task automatic seq_lit(input int n, input string nm, input int ed0,
                         input int ed12, input int eacc, input int eaddr);
    seq(n);
    drive(0, 0, 0, 0);
    chk({nm, " valid_early"}, d0_valid, 0);
    drive(0, 0, 0, 0);
    chk({nm, " valid_lat2"}, d0_valid, 1);
    chk({nm, " data"}, d0_data, ed0);
    chk({nm, " data_sh12"}, d1_data, ed12);
    chk({nm, " acc"}, d0_acc, eacc);
    chk({nm, " addr"}, d0_addr, eaddr);
  endtask

  task automatic fill(input int p, input int w);
    for (int k = 0; k < 16; k++) begin
      g_pix[k] = p;
      g_wgt[k] = w;
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " data"}, d0_data, 0);
    chk({nm, " addr"}, d0_addr, 0);
    chk({nm, " valid"}, d0_valid, 0);
    chk({nm, " acc"}, d0_acc, 0);
    chk({nm, " done"}, d0_done, 0);
    chk({nm, " fd"}, d0_fd, 0);
    chk({nm, " err"}, d0_err, 0);
    chk({nm, " err_sh12"}, d1_err, 0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      exp_t e;
      chk("done_eq_valid", d0_done, d0_valid);
      chk("valid_sh12", d1_valid, d0_valid);
      if (d0_valid) begin
        if (m_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = m_q.pop_front();
          m_err_cur = e.err;
          chk("m_data", d0_data, e.d0);
          chk("m_data_sh12", d1_data, e.d12);
          chk("m_acc", d0_acc, e.acc);
          chk("m_addr", d0_addr, e.addr);
          chk("m_addr_sh12", d1_addr, e.addr);
          chk("m_fd", d0_fd, (e.addr == 675) ? 1 : 0);
          if (d0_fd) n_fd++;
        end
      end else begin
        chk("fd_idle", d0_fd, 0);
      end
      chk("m_err", d0_err, m_err_cur);
    end
  end

  int exp_d, exp_n90_12;

  initial begin
    #2;
    chk_zero("reset_state");
    @(negedge clk);
    #1 reset = 1'b1;

    fill(1, 1);
    seq_lit(9, "ones", 9, 0, 9, 0);
    chk("ones err", d0_err, 0);

`ifdef CONV_PU_RELU_EN
    exp_d = 0;
    exp_n90_12 = 0;
`else
    exp_d = 8'hA6;
    exp_n90_12 = 8'hFF;
`endif
    fill(10, -1);
    seq_lit(9, "neg90", exp_d, exp_n90_12, -90, 1);

`ifdef CONV_PU_RELU_EN
    exp_d = 255;
`else
    exp_d = 127;
`endif
    fill(255, 127);
    seq_lit(9, "max", exp_d, 71, 291465, 2);

    fill(2, 3);
    seq_lit(8, "short", 48, 0, 48, 3);
    chk("short err", d0_err, 1);

    fill(1, 1);
    seq_lit(9, "after_short", 9, 0, 9, 4);
    chk("after_short err", d0_err, 1);

    for (int k = 0; k < 9; k++) begin
      g_pix[k] = k + 1;
      g_wgt[k] = 2;
    end
    seq(9);
    seq(9);
    for (int t = 0; t <= 5; t++)
      drive(1, 0, (t >= 1) ? g_pix[t-1] : 0, (t >= 1) ? g_wgt[t-1] : 0);
    @(posedge clk);
    #2;
    chk("pre_reset queue", m_q.size(), 0);
    reset = 1'b0;
    model_reset();
    start_pu = 1'b0;
    #1;
    chk_zero("async_reset");
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk_zero("held_reset");
    #1 reset = 1'b1;
    seq_lit(9, "post_reset", 90, 0, 90, 0);

    drive(0, 0, 0, 0);
    #1 reset = 1'b0;
    model_reset();
    drive(0, 0, 0, 0);
    #1 reset = 1'b1;
    n_fd = 0;
    for (int i = 0; i < 677; i++) begin
      for (int k = 0; k < 9; k++) begin
        g_pix[k] = (i * 7 + k * 31) & 255;
        g_wgt[k] = ((i * 3 + k * 11) % 256) - 128;
      end
      seq(9);
    end
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("wrap valid", d0_valid, 1);
    chk("wrap addr", d0_addr, 0);
    for (int t = 0; t < 4; t++) drive(0, 0, 0, 0);
    chk("frame_done count", n_fd, 1);
    chk("queue drained", m_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
